universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised universal shift register; successor to the single-bit SISO stage.
//  Supports hold, shift-right, shift-left and parallel load, selected per cycle.
//  Serial out at both ends and parallel out, so one block covers SISO/SIPO/PISO/PIPO.
//  A shift counter pulses o_frame once every WIDTH shifts, for framing serial words.
// PARAMETERS
//  WIDTH   8               register width in bits, >= 2
//  CNT_W   $clog2(WIDTH)   localparam; width of o_cnt
// PORTS
//  in_clk    in   1        clock; all state updates on the rising edge
//  in_rst    in   1        asynchronous, active-high reset
//  in_en     in   1        clock enable; 0 = hold everything
//  in_mode   in   2        00 hold, 01 shift right, 10 shift left, 11 parallel load
//  in_sr     in   1        serial in for shift right; enters at bit WIDTH-1
//  in_sl     in   1        serial in for shift left; enters at bit 0
//  in_d      in   WIDTH    parallel load data
//  o_q       out  WIDTH    register contents
//  o_sout_r  out  1        = o_q[0]; serial out for shift right
//  o_sout_l  out  1        = o_q[WIDTH-1]; serial out for shift left
//  o_cnt     out  CNT_W    shifts completed in the current frame, 0..WIDTH-1
//  o_frame   out  1        registered one-cycle pulse: WIDTH-th shift of a frame done
// BEHAVIOUR
//  - Reset is asynchronous on in_rst rising, whatever the clock. o_q=0, o_cnt=0, o_frame=0.
//    A reset in mid-frame discards the partial word and the count.
//  - in_en=0: q and cnt hold. o_frame=0 on the next edge.
//  - in_en=1, mode 00: same as in_en=0.
//  - mode 01: q <= {in_sr, q[WIDTH-1:1]}.
//  - mode 10: q <= {q[WIDTH-2:0], in_sl}.
//  - mode 11: q <= in_d. cnt <= 0 and o_frame <= 0; a load starts a new frame.
//  - Count on a shift (01 or 10 with en=1):
//    - cnt==WIDTH-1: cnt <= 0 and o_frame <= 1.
//    - otherwise: cnt <= cnt+1 and o_frame <= 0.
//  - Changing direction mid-frame does not clear cnt. Both directions count toward one frame.
//  - o_frame stays high for exactly one cycle. Back-to-back frames give a pulse every WIDTH shifts.
//  - Latency: o_q reflects an operation 1 cycle after the edge that samples it.
//    o_sout_r, o_sout_l and o_q are combinational views of the state register, with no extra delay.
//  - Serial data is sampled only on the active edge. in_sr and in_sl are ignored in the other modes.
//  - in_mode values are fully decoded. No X-propagation default; an unknown value is treated as hold.
// STRUCTURE
//  - Shared package usr_pkg: localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
//  - Sub-module shift_frame_counter #(WIDTH):
//    - inputs in_clk, in_rst, in_shift, in_clr; outputs o_cnt, o_frame.
//    - Holds the wrap and pulse logic.
//  - The data path (q register plus a 4-way next-state mux) lives in the top level.
// TESTING
//  1. Reset: drive in_rst=1 between clock edges while o_q=8'hFF.
//     -> o_q=0, o_cnt=0, o_frame=0 at once, with no clock edge.
//  2. PISO: load 8'hC5, then 8 shift-right cycles with in_sr=0.
//     -> o_sout_r before each edge reads 1,0,1,0,0,0,1,1.
//     -> o_frame=1 only after the 8th edge; final o_q=8'h00.
//  3. SIPO: from reset, 8 shift-left cycles feeding in_sl = bits of 8'hC5, LSB first.
//     -> o_q=8'hA3, o_cnt=0, one o_frame pulse.
//  4. Enable and hold: after 3 shifts, hold in_en=0 for 5 cycles, then mode 00 for 2 cycles.
//     -> o_q and o_cnt=3 unchanged; o_frame stays 0.
//  5. Mid-frame load: after 5 shifts, load 8'h3C.
//     -> o_cnt=0 and o_q=8'h3C; a frame pulse follows only after 8 more shifts.
//  6. Mixed direction: shift right 4 times, then left 4 times.
//     -> o_frame pulses after the 8th shift in total.
//     -> 16 consecutive shifts give two pulses, 8 cycles apart.

Source files
------------

// File: rtl/usr_pkg.sv
// Purpose : shared mode encodings for the universal shift register.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/shift_frame_counter.sv
// Purpose : counts shifts modulo WIDTH and pulses o_frame on the wrap.
// Ports   : in_clk, in_rst (async, active-high)
//           in_shift  one shift happens this cycle
//           in_clr    restart the frame (parallel load)
//           o_cnt     shifts completed in the current frame
//           o_frame   registered one-cycle pulse after the WIDTH-th shift
module shift_frame_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_shift,
    input  logic                       in_clr,
    output logic [$clog2(WIDTH)-1:0]   o_cnt,
    output logic                       o_frame
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_frame;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_frame_nxt;

    // Next count / pulse; the pulse only ever lasts the cycle after a wrap.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = 1'b0;
        if (in_clr) begin
            w_cnt_nxt = '0;
        end else if (in_shift) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt   = '0;
                w_frame_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_frame = r_frame;

endmodule : shift_frame_counter

// File: rtl/universal_shift_reg.sv
// Purpose : universal shift register (hold / shift right / shift left / load)
//           with serial outs at both ends and a WIDTH-shift framing pulse.
// Ports   : in_clk, in_rst (async, active-high), in_en (clock enable)
//           in_mode   00 hold, 01 shift right, 10 shift left, 11 load
//           in_sr     serial in entering at bit WIDTH-1 on shift right
//           in_sl     serial in entering at bit 0 on shift left
//           in_d      parallel load data
//           o_q       register contents
//           o_sout_r  bit 0, o_sout_l bit WIDTH-1
//           o_cnt     shifts in current frame, o_frame frame-done pulse
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_en,
    input  logic [1:0]                 in_mode,
    input  logic                       in_sr,
    input  logic                       in_sl,
    input  logic [WIDTH-1:0]           in_d,
    output logic [WIDTH-1:0]           o_q,
    output logic                       o_sout_r,
    output logic                       o_sout_l,
    output logic [$clog2(WIDTH)-1:0]   o_cnt,
    output logic                       o_frame
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_shift;
    logic             w_clr;

    // Data path next-state mux; anything not a recognised op holds.
    always_comb begin
        w_q_nxt = r_q;
        if (in_en) begin
            case (in_mode)
                MODE_SHR:  w_q_nxt = {in_sr, r_q[WIDTH-1:1]};
                MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], in_sl};
                MODE_LOAD: w_q_nxt = in_d;
                default:   w_q_nxt = r_q;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) r_q <= '0;
        else        r_q <= w_q_nxt;
    end

    // Both shift directions feed one shared frame count.
    assign w_shift = in_en && ((in_mode == MODE_SHR) || (in_mode == MODE_SHL));
    assign w_clr   = in_en && (in_mode == MODE_LOAD);

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_shift (w_shift),
        .in_clr   (w_clr),
        .o_cnt    (o_cnt),
        .o_frame  (o_frame)
    );

    assign o_q      = r_q;
    assign o_sout_r = r_q[0];
    assign o_sout_l = r_q[WIDTH-1];

endmodule : universal_shift_reg
